tlul_adapter_host_mo: RTL and testbench
=======================================

TLUL_ADAPTER_HOST_MO -- requirements
Module: tlul_adapter_host_mo

Interface
REQ-001 The block SHALL have parameter AW, default 32: address width.
REQ-002 The block SHALL have parameter DW, default 32: data width; legal values are 32 and 64, and DBW=DW/8.
REQ-003 The block SHALL have parameter MAX_REQS, default 2: outstanding-transaction slots; legal range 1..16, SW=max(1,clog2(MAX_REQS)).
REQ-004 The block SHALL have parameter SRC_BASE, default 8'h00: first TL source ID; SRC_BASE+MAX_REQS-1 SHALL be at most 255.
REQ-005 The block SHALL have the following ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  host request.
- gnt_o  out  1  host request accepted this cycle.
- addr_i  in  AW  byte address.
- we_i  in  1  write.
- wdata_i  in  DW  write data.
- be_i  in  DBW  byte enables.
- size_i  in  2  log2 bytes.
- valid_o  out  1  response to host, in issue order.
- rdata_o  out  DW  read data.
- err_o  out  1  response carried d_error.
- unexp_o  out  1  sticky: a D beat arrived for a non-pending source.
- tl_a_valid_o  out  1  A channel valid.
- tl_a_opcode_o  out  3  A channel opcode.
- tl_a_size_o  out  2  A channel size.
- tl_a_source_o  out  8  A channel source ID.
- tl_a_address_o  out  AW  A channel address.
- tl_a_mask_o  out  DBW  A channel byte mask.
- tl_a_data_o  out  DW  A channel data.
- tl_a_ready_i  in  1  A channel ready.
- tl_d_valid_i  in  1  D channel valid.
- tl_d_source_i  in  8  D channel source ID.
- tl_d_data_i  in  DW  D channel data.
- tl_d_error_i  in  1  D channel error.
- tl_d_ready_o  out  1  D channel ready.

Function
REQ-006 Each slot SHALL hold state FREE, PEND (issued, awaiting D) or DONE (response stored), plus data, error and write bits.
REQ-007 alloc_ptr and retire_ptr (SW bits) SHALL wrap from MAX_REQS-1 to 0.
REQ-008 tl_a_valid_o SHALL equal req_i AND slot[alloc_ptr]==FREE, combinationally.
REQ-009 gnt_o SHALL equal tl_a_valid_o AND tl_a_ready_i.
REQ-010 All MAX_REQS slots non-FREE SHALL hold tl_a_valid_o=0 and gnt_o=0.
REQ-011 tl_a_address_o, tl_a_data_o, tl_a_size_o and tl_a_mask_o SHALL pass through addr_i, wdata_i, size_i and be_i.
REQ-012 tl_a_source_o SHALL equal SRC_BASE+alloc_ptr.
REQ-013 tl_a_opcode_o SHALL be 3'h4 (Get) when we_i=0, 3'h0 (PutFullData) when we_i=1 and be_i is all ones, and 3'h1 (PutPartialData) otherwise.
REQ-014 On gnt_o, slot[alloc_ptr] SHALL become PEND, record we_i, and alloc_ptr SHALL advance.
REQ-015 tl_d_ready_o SHALL be constant 1, since a slot is reserved per issue.
REQ-016 A D beat with idx=tl_d_source_i-SRC_BASE, idx<MAX_REQS and slot[idx]==PEND SHALL move the slot to DONE and store tl_d_data_i (0 if the slot is a write) and tl_d_error_i.
REQ-017 Any other D beat SHALL be dropped and SHALL set unexp_o, which stays set until reset.
REQ-018 valid_o SHALL be 1 while slot[retire_ptr]==DONE, with rdata_o and err_o taken from that slot.
REQ-019 rdata_o and err_o SHALL be 0 when valid_o=0.
REQ-020 On valid_o, the host is not back-pressured: the slot SHALL become FREE at that edge and retire_ptr SHALL advance.
REQ-021 Latency SHALL be one cycle minimum from D handshake to valid_o.
REQ-022 Out-of-order D responses SHALL be held until all earlier slots retire.
REQ-023 Same-cycle grant, D store and retire on different slots SHALL all take effect.
REQ-024 A slot freed by retire SHALL NOT be grantable until the following cycle.

Reset
REQ-025 While rst_ni=0, all slots SHALL be FREE, both pointers 0, unexp_o=0, and valid_o, err_o and rdata_o 0.
REQ-026 The A-channel outputs SHALL be combinational from inputs and state during reset.
REQ-027 Reset mid-operation SHALL discard all pending work; D beats after release for pre-reset sources SHALL set unexp_o.

Verification
REQ-028 Read at MAX_REQS=2, with a_ready=1, req at 0x100: tl_a_opcode_o=4 and source=SRC_BASE; D data 0xDEADBEEF two cycles later -> valid_o one cycle after the D beat, with rdata_o=0xDEADBEEF and err_o=0.
REQ-029 Three back-to-back reads at MAX_REQS=2 with no D response -> gnt on the first two and gnt_o=0 on the third until the first retires.
REQ-030 Two reads with responses in order source 1 then 0 -> valid_o for source-0 data first and source-1 data the next cycle.
REQ-031 Write with be=4'b0011 -> opcode 1; write with be=4'hF -> opcode 0; D error on the second -> err_o=1 and rdata_o=0.
REQ-032 D beat with source SRC_BASE+5 at MAX_REQS=2 -> unexp_o=1 sticky, with no valid_o.
REQ-033 Reset asserted with two reads pending -> all outputs cleared, and responses arriving after release set unexp_o.

Source files
------------

// File: rtl/tlul_adapter_host_mo.sv
// tlul_adapter_host_mo
//   Host-side TL-UL adapter that allows up to MAX_REQS transactions in flight.
//   Each transaction gets a slot; the slot index plus SRC_BASE is the A source ID.
//   D responses may arrive in any order. They are buffered per slot and handed
//   back to the host strictly in issue order.
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/gnt_o          host request and accept handshake
//   addr_i, we_i, wdata_i, be_i, size_i   host request fields
//   valid_o, rdata_o, err_o               in-order host response
//   unexp_o              sticky flag: a D beat arrived for a source that is not pending
//   tl_a_*               TL-UL A channel (request)
//   tl_d_*               TL-UL D channel (response); ready is always 1
module tlul_adapter_host_mo #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_REQS = 2,
  parameter logic [7:0]  SRC_BASE = 8'h00
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   addr_i,
  input  logic            we_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [1:0]      size_i,
  output logic            valid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            err_o,
  output logic            unexp_o,
  output logic            tl_a_valid_o,
  output logic [2:0]      tl_a_opcode_o,
  output logic [1:0]      tl_a_size_o,
  output logic [7:0]      tl_a_source_o,
  output logic [AW-1:0]   tl_a_address_o,
  output logic [DW/8-1:0] tl_a_mask_o,
  output logic [DW-1:0]   tl_a_data_o,
  input  logic            tl_a_ready_i,
  input  logic            tl_d_valid_i,
  input  logic [7:0]      tl_d_source_i,
  input  logic [DW-1:0]   tl_d_data_i,
  input  logic            tl_d_error_i,
  output logic            tl_d_ready_o
);

  localparam int unsigned SW = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;

  typedef enum logic [1:0] {
    SLOT_FREE = 2'd0,
    SLOT_PEND = 2'd1,
    SLOT_DONE = 2'd2
  } slot_st_e;

  slot_st_e          st_q    [MAX_REQS];
  slot_st_e          st_d    [MAX_REQS];
  logic [DW-1:0]     data_q  [MAX_REQS];
  logic [DW-1:0]     data_d  [MAX_REQS];
  logic              err_q   [MAX_REQS];
  logic              err_d   [MAX_REQS];
  logic              wr_q    [MAX_REQS];
  logic              wr_d    [MAX_REQS];
  logic [SW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [SW-1:0]     retire_ptr_q, retire_ptr_d;
  logic              unexp_q, unexp_d;

  logic [7:0]        d_idx;
  logic [SW-1:0]     d_slot;
  logic              d_hit;
  logic              retire;

  function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
    return (p == SW'(MAX_REQS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Source IDs below SRC_BASE wrap to large values and fall out of range.
  assign d_idx  = tl_d_source_i - SRC_BASE;
  assign d_slot = d_idx[SW-1:0];
  assign d_hit  = tl_d_valid_i && (d_idx < 8'(MAX_REQS)) && (st_q[d_slot] == SLOT_PEND);
  assign retire = (st_q[retire_ptr_q] == SLOT_DONE);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_REQS; i++) begin
        st_q[i]   <= SLOT_FREE;
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
        wr_q[i]   <= 1'b0;
      end
      alloc_ptr_q  <= '0;
      retire_ptr_q <= '0;
      unexp_q      <= 1'b0;
    end else begin
      st_q         <= st_d;
      data_q       <= data_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      alloc_ptr_q  <= alloc_ptr_d;
      retire_ptr_q <= retire_ptr_d;
      unexp_q      <= unexp_d;
    end
  end

  // Next state. Grant targets a FREE slot, store a PEND slot and retire a DONE
  // slot, so all three can update in the same cycle without colliding.
  always_comb begin
    st_d         = st_q;
    data_d       = data_q;
    err_d        = err_q;
    wr_d         = wr_q;
    alloc_ptr_d  = alloc_ptr_q;
    retire_ptr_d = retire_ptr_q;
    unexp_d      = unexp_q | (tl_d_valid_i & ~d_hit);

    if (gnt_o) begin
      st_d[alloc_ptr_q] = SLOT_PEND;
      wr_d[alloc_ptr_q] = we_i;
      alloc_ptr_d       = ptr_inc(alloc_ptr_q);
    end
    if (d_hit) begin
      st_d[d_slot]   = SLOT_DONE;
      data_d[d_slot] = wr_q[d_slot] ? '0 : tl_d_data_i;
      err_d[d_slot]  = tl_d_error_i;
    end
    if (retire) begin
      st_d[retire_ptr_q] = SLOT_FREE;
      retire_ptr_d       = ptr_inc(retire_ptr_q);
    end
  end

  // Outputs
  always_comb begin
    tl_a_valid_o   = req_i && (st_q[alloc_ptr_q] == SLOT_FREE);
    gnt_o          = tl_a_valid_o && tl_a_ready_i;
    tl_a_source_o  = SRC_BASE + 8'(alloc_ptr_q);
    tl_a_address_o = addr_i;
    tl_a_data_o    = wdata_i;
    tl_a_size_o    = size_i;
    tl_a_mask_o    = be_i;
    if (!we_i)      tl_a_opcode_o = 3'h4;
    else if (&be_i) tl_a_opcode_o = 3'h0;
    else            tl_a_opcode_o = 3'h1;
    tl_d_ready_o   = 1'b1;
    valid_o        = retire;
    rdata_o        = retire ? data_q[retire_ptr_q] : '0;
    err_o          = retire ? err_q[retire_ptr_q] : 1'b0;
    unexp_o        = unexp_q;
  end

endmodule

// File: tb/tb_tlul_adapter_host_mo.sv
// Directed testbench for tlul_adapter_host_mo with MAX_REQS=2 and SRC_BASE=8'h10.
module tb_tlul_adapter_host_mo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, we, valid, err, unexp;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [1:0]  size;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_error, d_ready;
  logic [7:0]  d_source;
  logic [31:0] d_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tlul_adapter_host_mo #(
    .AW(32), .DW(32), .MAX_REQS(2), .SRC_BASE(8'h10)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .be_i(be), .size_i(size),
    .valid_o(valid), .rdata_o(rdata), .err_o(err), .unexp_o(unexp),
    .tl_a_valid_o(a_valid), .tl_a_opcode_o(a_opcode), .tl_a_size_o(a_size),
    .tl_a_source_o(a_source), .tl_a_address_o(a_address), .tl_a_mask_o(a_mask),
    .tl_a_data_o(a_data), .tl_a_ready_i(a_ready),
    .tl_d_valid_i(d_valid), .tl_d_source_i(d_source), .tl_d_data_i(d_data),
    .tl_d_error_i(d_error), .tl_d_ready_o(d_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF; size = 2'd2;
    a_ready = 1'b1; d_valid = 1'b0; d_source = '0; d_data = '0; d_error = 1'b0;

    // Reset state; A channel stays combinational during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_unexp", unexp, 0);
    req = 1'b1; addr = 32'h100;
    #1;
    chk("rst_a_valid", a_valid, 1);
    chk("rst_a_source", a_source, 8'h10);
    req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single read, D two cycles after issue
    req = 1'b1; addr = 32'h100; we = 1'b0; be = 4'hF; size = 2'd2;
    #1;
    chk("rd_a_valid", a_valid, 1);
    chk("rd_gnt", gnt, 1);
    chk("rd_opcode", a_opcode, 3'h4);
    chk("rd_source", a_source, 8'h10);
    chk("rd_address", a_address, 32'h100);
    chk("rd_size", a_size, 2'd2);
    chk("d_ready", d_ready, 1);
    tick();
    req = 1'b0;
    tick();
    d_valid = 1'b1; d_source = 8'h10; d_data = 32'hDEADBEEF;
    #1;
    chk("rd_valid_same_cycle", valid, 0);
    tick();
    d_valid = 1'b0;
    #1;
    chk("rd_valid", valid, 1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_err", err, 0);
    tick();
    #1;
    chk("rd_valid_after", valid, 0);
    chk("rd_rdata_after", rdata, 0);

    // Back-to-back reads fill both slots; third is blocked
    req = 1'b1;
    #1;
    chk("b2b_gnt0", gnt, 1);
    chk("b2b_src0", a_source, 8'h11);
    tick();
    #1;
    chk("b2b_gnt1", gnt, 1);
    chk("b2b_src1", a_source, 8'h10);
    tick();
    #1;
    chk("full_gnt", gnt, 0);
    chk("full_a_valid", a_valid, 0);
    tick();
    #1;
    chk("full_gnt2", gnt, 0);
    d_valid = 1'b1; d_source = 8'h11; d_data = 32'h0000_0111;
    tick();
    d_valid = 1'b0;
    #1;
    chk("full_ret_valid", valid, 1);
    chk("full_ret_rdata", rdata, 32'h0000_0111);
    chk("full_ret_gnt", gnt, 0);
    tick();
    #1;
    chk("freed_valid", valid, 0);
    chk("freed_gnt", gnt, 1);
    chk("freed_src", a_source, 8'h11);
    tick();
    req = 1'b0;

    // Out-of-order D: source 0x11 first, then 0x10
    d_valid = 1'b1; d_source = 8'h11; d_data = 32'h1111_1111;
    tick();
    d_source = 8'h10; d_data = 32'h0000_AAAA;
    #1;
    chk("ooo_held", valid, 0);
    tick();
    d_valid = 1'b0;
    #1;
    chk("ooo_valid0", valid, 1);
    chk("ooo_rdata0", rdata, 32'h0000_AAAA);
    tick();
    #1;
    chk("ooo_valid1", valid, 1);
    chk("ooo_rdata1", rdata, 32'h1111_1111);
    tick();
    #1;
    chk("ooo_idle", valid, 0);

    // Writes: partial then full mask, error on the second
    req = 1'b1; we = 1'b1; be = 4'b0011; wdata = 32'hA5A5_5A5A; addr = 32'h200;
    #1;
    chk("wr_pp_opcode", a_opcode, 3'h1);
    chk("wr_pp_mask", a_mask, 4'b0011);
    chk("wr_pp_data", a_data, 32'hA5A5_5A5A);
    chk("wr_pp_gnt", gnt, 1);
    tick();
    be = 4'hF; wdata = 32'h0F0F_F0F0;
    #1;
    chk("wr_pf_opcode", a_opcode, 3'h0);
    chk("wr_pf_src", a_source, 8'h11);
    tick();
    req = 1'b0; we = 1'b0;
    d_valid = 1'b1; d_source = 8'h10; d_data = 32'h1234_5678; d_error = 1'b0;
    tick();
    d_source = 8'h11; d_data = 32'h0000_0055; d_error = 1'b1;
    #1;
    chk("wr0_valid", valid, 1);
    chk("wr0_rdata", rdata, 0);
    chk("wr0_err", err, 0);
    tick();
    d_valid = 1'b0; d_error = 1'b0;
    #1;
    chk("wr1_valid", valid, 1);
    chk("wr1_rdata", rdata, 0);
    chk("wr1_err", err, 1);
    tick();
    #1;
    chk("wr_idle_valid", valid, 0);
    chk("wr_idle_err", err, 0);

    // Unexpected source
    d_valid = 1'b1; d_source = 8'h15; d_data = 32'h5555_5555;
    tick();
    d_valid = 1'b0;
    #1;
    chk("unexp_set", unexp, 1);
    chk("unexp_no_valid", valid, 0);
    tick();
    tick();
    #1;
    chk("unexp_sticky", unexp, 1);

    // Reset with work in flight
    req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    d_valid = 1'b1; d_source = 8'h10; d_data = 32'h0000_0077;
    tick();
    d_valid = 1'b0;
    #1;
    chk("prerst_valid", valid, 1);
    chk("prerst_rdata", rdata, 32'h0000_0077);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", valid, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_unexp", unexp, 0);
    chk("mrst_a_valid_idle", a_valid, 0);
    req = 1'b1;
    #1;
    chk("mrst_a_valid", a_valid, 1);
    chk("mrst_src", a_source, 8'h10);
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    d_valid = 1'b1; d_source = 8'h11; d_data = 32'h0000_0099;
    tick();
    d_valid = 1'b0;
    #1;
    chk("postrst_unexp", unexp, 1);
    chk("postrst_valid", valid, 0);
    req = 1'b1;
    #1;
    chk("postrst_gnt", gnt, 1);
    chk("postrst_src", a_source, 8'h10);
    req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
